otter_mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the MCU instruction-fetch port (read-only) and the data port (read/write with byte strobes).
- Holds one outstanding transaction at a time.
- Data requests have priority, and a streak limit stops them from starving fetch.
- A watchdog timeout returns an error response if memory never acknowledges.

---
 rtl/otter_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_otter_mem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/otter_mem_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch and data access ports.
// One outstanding transaction; grants are combinational in IDLE, and rvalid arrives the cycle after mem_ack or timeout.
module otter_mem_arbiter #(
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_r_data,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_strb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_w_data,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_r_data,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_strb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_w_data,
    input  logic        mem_ack,
    input  logic [31:0] mem_r_data
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  streak_q, streak_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_strb_q, mem_strb_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_w_data_q, mem_w_data_d;
    logic        i_rvalid_q, i_rvalid_d, i_err_q, i_err_d;
    logic        d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
    logic [31:0] i_r_data_q, i_r_data_d, d_r_data_q, d_r_data_d;
    logic        done, done_err;
    logic [31:0] done_data;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        streak_d     = streak_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_strb_d   = mem_strb_q;
        mem_addr_d   = mem_addr_q;
        mem_w_data_d = mem_w_data_q;
        i_gnt        = 1'b0;
        d_gnt        = 1'b0;
        done         = 1'b0;
        done_err     = 1'b0;
        done_data    = 32'h0;

        case (state_q)
            IDLE: begin
                // A grant during reset would be lost, so hold requesters off until it drops.
                if (!rst) begin
                    if (d_req && (!i_req || streak_q < STREAK_MAX)) begin
                        d_gnt = 1'b1;
                    end else if (i_req) begin
                        i_gnt = 1'b1;
                    end
                end
                if (d_gnt) begin
                    state_d      = BUSY_D;
                    cnt_d        = 8'h0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = d_we;
                    mem_strb_d   = d_strb;
                    mem_addr_d   = d_addr;
                    mem_w_data_d = d_w_data;
                    if (!i_req) begin
                        streak_d = 4'h0;
                    end else if (streak_q < STREAK_MAX) begin
                        streak_d = streak_q + 4'h1;
                    end
                end else if (i_gnt) begin
                    state_d      = BUSY_I;
                    cnt_d        = 8'h0;
                    streak_d     = 4'h0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_strb_d   = 4'h0;
                    mem_addr_d   = i_addr;
                    mem_w_data_d = 32'h0;
                end
            end
            BUSY_I, BUSY_D: begin
                // An ack in the timeout cycle takes precedence over the error.
                if (mem_ack) begin
                    done      = 1'b1;
                    done_data = mem_we_q ? 32'h0 : mem_r_data;
                end else begin
                    cnt_d = cnt_q + 8'h1;
                    if (cnt_q == TMO_LAST) begin
                        done     = 1'b1;
                        done_err = 1'b1;
                    end
                end
                if (done) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        i_rvalid_d = done && (state_q == BUSY_I);
        i_err_d    = done_err && (state_q == BUSY_I);
        i_r_data_d = (state_q == BUSY_I) ? done_data : 32'h0;
        d_rvalid_d = done && (state_q == BUSY_D);
        d_err_d    = done_err && (state_q == BUSY_D);
        d_r_data_d = (state_q == BUSY_D) ? done_data : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'h0;
            streak_q     <= 4'h0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_strb_q   <= 4'h0;
            mem_addr_q   <= 32'h0;
            mem_w_data_q <= 32'h0;
            i_rvalid_q   <= 1'b0;
            i_err_q      <= 1'b0;
            i_r_data_q   <= 32'h0;
            d_rvalid_q   <= 1'b0;
            d_err_q      <= 1'b0;
            d_r_data_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            streak_q     <= streak_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_strb_q   <= mem_strb_d;
            mem_addr_q   <= mem_addr_d;
            mem_w_data_q <= mem_w_data_d;
            i_rvalid_q   <= i_rvalid_d;
            i_err_q      <= i_err_d;
            i_r_data_q   <= i_r_data_d;
            d_rvalid_q   <= d_rvalid_d;
            d_err_q      <= d_err_d;
            d_r_data_q   <= d_r_data_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_strb   = mem_strb_q;
    assign mem_addr   = mem_addr_q;
    assign mem_w_data = mem_w_data_q;
    assign i_rvalid   = i_rvalid_q;
    assign i_err      = i_err_q;
    assign i_r_data   = i_r_data_q;
    assign d_rvalid   = d_rvalid_q;
    assign d_err      = d_err_q;
    assign d_r_data   = d_r_data_q;
endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter: fetch, write, arbitration fairness, timeout, ack-on-timeout, reset abort.
module tb_otter_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_gnt, i_rvalid, i_err;
    logic [31:0] i_addr, i_r_data;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [3:0]  d_strb;
    logic [31:0] d_addr, d_w_data, d_r_data;
    logic        mem_req, mem_we, mem_ack;
    logic [3:0]  mem_strb;
    logic [31:0] mem_addr, mem_w_data, mem_r_data;

    int checks = 0;
    int errors = 0;

    otter_mem_arbiter #(.TIMEOUT(16), .MAX_D_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_r_data(i_r_data), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_strb(d_strb), .d_addr(d_addr),
        .d_w_data(d_w_data), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_r_data(d_r_data), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_strb(mem_strb),
        .mem_addr(mem_addr), .mem_w_data(mem_w_data),
        .mem_ack(mem_ack), .mem_r_data(mem_r_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [6:0]  pat;
    logic        prev_d;
    logic [31:0] prev_dat;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_strb = 4'h0; d_addr = 32'h0; d_w_data = 32'h0; mem_ack = 1'b0; mem_r_data = 32'h0;
        tick(); tick();
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_i_rvalid", i_rvalid, 1'b0);
        chk1("rst_d_rvalid", d_rvalid, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;

        // Single fetch, ack two cycles after mem_req rises
        i_req = 1'b1; i_addr = 32'h100; #1;
        chk1("fetch_i_gnt", i_gnt, 1'b1);
        chk1("fetch_d_gnt", d_gnt, 1'b0);
        tick(); i_req = 1'b0; #1;
        chk1("fetch_mem_req", mem_req, 1'b1);
        chk32("fetch_mem_addr", mem_addr, 32'h100);
        chk1("fetch_mem_we", mem_we, 1'b0);
        chk1("fetch_busy_gnt", i_gnt, 1'b0);
        tick();
        chk1("fetch_wait_rvalid", i_rvalid, 1'b0);
        tick(); mem_ack = 1'b1; mem_r_data = 32'h00500093;
        tick(); mem_ack = 1'b0;
        chk1("fetch_rvalid", i_rvalid, 1'b1);
        chk32("fetch_rdata", i_r_data, 32'h00500093);
        chk1("fetch_err", i_err, 1'b0);
        chk1("fetch_done_mem_req", mem_req, 1'b0);
        tick();
        chk1("fetch_rvalid_pulse", i_rvalid, 1'b0);

        // Data write with immediate ack
        d_req = 1'b1; d_we = 1'b1; d_strb = 4'h3; d_addr = 32'h2000; d_w_data = 32'hABCD1234; #1;
        chk1("wr_d_gnt", d_gnt, 1'b1);
        tick(); d_req = 1'b0;
        chk1("wr_mem_we", mem_we, 1'b1);
        chk32("wr_mem_strb", {28'h0, mem_strb}, 32'h3);
        chk32("wr_mem_wdata", mem_w_data, 32'hABCD1234);
        chk32("wr_mem_addr", mem_addr, 32'h2000);
        mem_ack = 1'b1; mem_r_data = 32'hFFFFFFFF;
        tick(); mem_ack = 1'b0;
        chk1("wr_rvalid", d_rvalid, 1'b1);
        chk32("wr_rdata", d_r_data, 32'h0);
        chk1("wr_err", d_err, 1'b0);

        // Both requesting continuously: expect D D D D I D D
        pat = 7'b1101111;
        d_we = 1'b0; d_strb = 4'h0; d_addr = 32'h4000; i_addr = 32'h300;
        i_req = 1'b1; d_req = 1'b1;
        prev_d = 1'b0; prev_dat = 32'h0;
        for (int g = 0; g < 7; g++) begin
            #1;
            chk1($sformatf("arb%0d_d_gnt", g), d_gnt, pat[g]);
            chk1($sformatf("arb%0d_i_gnt", g), i_gnt, ~pat[g]);
            if (g > 0) begin
                chk1($sformatf("arb%0d_d_rvalid", g), d_rvalid, prev_d);
                chk1($sformatf("arb%0d_i_rvalid", g), i_rvalid, ~prev_d);
                chk32($sformatf("arb%0d_rdata", g), prev_d ? d_r_data : i_r_data, prev_dat);
            end
            tick();
            chk1($sformatf("arb%0d_busy_gnt", g), i_gnt | d_gnt, 1'b0);
            mem_ack = 1'b1; mem_r_data = 32'hA0 + 32'(g);
            prev_d = pat[g]; prev_dat = 32'hA0 + 32'(g);
            tick(); mem_ack = 1'b0;
        end
        i_req = 1'b0; d_req = 1'b0; #1;
        chk1("arb_last_d_rvalid", d_rvalid, 1'b1);
        chk32("arb_last_rdata", d_r_data, 32'hA6);
        tick();

        // Timeout: no ack for 16 BUSY cycles
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; #1;
        chk1("tmo_d_gnt", d_gnt, 1'b1);
        tick(); d_req = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            chk1($sformatf("tmo_busy%0d_mem_req", j), mem_req, 1'b1);
            chk1($sformatf("tmo_busy%0d_rvalid", j), d_rvalid, 1'b0);
            tick();
        end
        chk1("tmo_rvalid", d_rvalid, 1'b1);
        chk1("tmo_err", d_err, 1'b1);
        chk32("tmo_rdata", d_r_data, 32'h0);
        chk1("tmo_mem_req", mem_req, 1'b0);
        mem_ack = 1'b1; mem_r_data = 32'h77;
        tick(); mem_ack = 1'b0;
        chk1("stray_mem_req", mem_req, 1'b0);
        chk1("stray_d_rvalid", d_rvalid, 1'b0);
        chk1("stray_i_rvalid", i_rvalid, 1'b0);

        // Ack arriving on the timeout cycle
        d_req = 1'b1; d_addr = 32'h3004; #1;
        chk1("acktmo_d_gnt", d_gnt, 1'b1);
        tick(); d_req = 1'b0;
        for (int j = 1; j <= 15; j++) tick();
        chk1("acktmo_busy_rvalid", d_rvalid, 1'b0);
        mem_ack = 1'b1; mem_r_data = 32'h55;
        tick(); mem_ack = 1'b0;
        chk1("acktmo_rvalid", d_rvalid, 1'b1);
        chk1("acktmo_err", d_err, 1'b0);
        chk32("acktmo_rdata", d_r_data, 32'h55);

        // Reset during BUSY_D abandons the transaction
        d_req = 1'b1; d_we = 1'b1; d_strb = 4'hF; d_addr = 32'h5000; d_w_data = 32'h12345678; #1;
        chk1("rstmid_d_gnt", d_gnt, 1'b1);
        tick(); d_req = 1'b0;
        tick();
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk1("rstmid_mem_req", mem_req, 1'b0);
        chk1("rstmid_mem_we", mem_we, 1'b0);
        chk1("rstmid_d_rvalid", d_rvalid, 1'b0);
        tick();
        chk1("rstmid_d_rvalid_after", d_rvalid, 1'b0);
        i_req = 1'b1; i_addr = 32'h200; #1;
        chk1("rstmid_i_gnt", i_gnt, 1'b1);
        tick(); i_req = 1'b0;
        chk32("rstmid_mem_addr", mem_addr, 32'h200);
        mem_ack = 1'b1; mem_r_data = 32'hDEADBEEF;
        tick(); mem_ack = 1'b0;
        chk1("rstmid_i_rvalid", i_rvalid, 1'b1);
        chk32("rstmid_i_rdata", i_r_data, 32'hDEADBEEF);
        chk1("rstmid_i_err", i_err, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
